// File: rtl/ram8_16_pkg.sv
// Shared Hack datapath constants: word width, RAM8 geometry and reset word.
package hack_defs;
  localparam int              HACK_WORD_W    = 16;
  localparam int              RAM8_ADDR_W    = 3;
  localparam int              RAM8_DEPTH     = 8;
  localparam logic [15:0]     HACK_WORD_ZERO = 16'h0000;
endpackage

// File: rtl/ram8_16_register16.sv
// WIDTH-bit load-enabled register with synchronous active-high clear.
module register16
  import hack_defs::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load) word_d = in;
  end

  // Reset dominates load so a write coincident with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) word_q <= WIDTH'(HACK_WORD_ZERO);
    else     word_q <= word_d;
  end

  assign out = word_q;
endmodule

// File: rtl/ram8_16.sv
// Hack RAM8: eight register16 words, 3-to-8 load decode, 8:1 combinational read mux.
// Optional macro RAM8_16_WRITE_BYPASS_EN forwards in to out during an active write.
module ram8_16
  import hack_defs::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = RAM8_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]            load_dec;
  logic [DEPTH-1:0][WIDTH-1:0] word_q;

  always_comb begin
    load_dec          = '0;
    load_dec[address] = load;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register16 #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .load (load_dec[i]),
      .out  (word_q[i])
    );
  end

  always_comb begin
    out = word_q[address];
`ifdef RAM8_16_WRITE_BYPASS_EN
    // Write-through forward; suppressed under reset since the write is dropped.
    if (load && !rst) out = in;
`endif
  end
endmodule

// File: tb/tb_ram8_16.sv
// Self-checking bench for ram8_16: array model compared every cycle plus directed literals.
module tb_ram8_16;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [8];
  logic        model_valid = 1'b0;
  logic        done = 1'b0;

  ram8_16 dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  always #5 clk = ~clk;

  // Model: an array of words with reset/write semantics straight from the rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) mem[k] <= 16'h0000;
      model_valid <= 1'b1;
    end else if (load) begin
      mem[address] <= in;
    end
  end

  function automatic logic [15:0] model_out();
    logic [15:0] e;
    e = mem[address];
`ifdef RAM8_16_WRITE_BYPASS_EN
    if (load && !rst) e = in;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (model_valid && !done) begin
      checks++;
      if (out !== model_out()) begin
        errors++;
        $display("FAIL model addr=%0d got %h want %h", address, out, model_out());
      end
    end
  end

  task automatic check(input string name, input logic [15:0] want);
    checks++;
    if (out !== want) begin
      errors++;
      $display("FAIL %s addr=%0d got %h want %h", name, address, out, want);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string name, input logic [15:0] base_mul, input logic zero);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      check(name, zero ? 16'h0000 : 16'(base_mul * (a + 1)));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in = 16'h0000; address = 3'd0;
    step();
    rst = 1'b0;
    sweep("reset_sweep", 16'h0000, 1'b1);

    for (int a = 0; a < 8; a++) begin
      address = 3'(a); in = 16'(16'h1111 * (a + 1)); load = 1'b1;
      step();
      load = 1'b0;
      #1;
      check("write_back", 16'(16'h1111 * (a + 1)));
    end
    sweep("readback_sweep", 16'h1111, 1'b0);

    address = 3'd3; in = 16'hffff; load = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("hold", 16'h4444);
    end

    address = 3'd5; in = 16'ha5a5; load = 1'b1;
    #1;
`ifdef RAM8_16_WRITE_BYPASS_EN
    check("latency_pre", 16'ha5a5);
`else
    check("latency_pre", 16'h6666);
`endif
    step();
    load = 1'b0;
    #1;
    check("latency_post", 16'ha5a5);

    rst = 1'b1; load = 1'b1; address = 3'd2; in = 16'hbeef;
    #1;
    check("rst_no_forward", 16'h3333);
    step();
    rst = 1'b0; load = 1'b0;
    #1;
    check("rst_prio_addr2", 16'h0000);
    sweep("rst_prio_sweep", 16'h0000, 1'b1);

    address = 3'd7; in = 16'h00ff; load = 1'b1;
    step();
    load = 1'b0;
    #1;
    check("mid_write", 16'h00ff);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_reset", 16'h0000);
    in = 16'hf00f; load = 1'b1;
    step();
    load = 1'b0;
    #1;
    check("mid_rewrite", 16'hf00f);

    step();
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram8_16.md
Name: ram8_16

Overview:
- 8-word x 16-bit random-access memory, the Hack RAM8 stage.
- Sits directly downstream of the 16-bit logic/ALU datapath (and16_gate and friends) and stores the words they produce.
- Built as eight register16 instances with a 3-bit address decode on write and an 8:1 mux on read.
- Base block for the later ram64/ram512 hierarchy.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W = 8 words.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- in  input  WIDTH  write data.
- load  input  1  write enable for the addressed word.
- address  input  ADDR_W  word select; used for both read and write.
- out  output  WIDTH  contents of word[address].

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). There is no asynchronous path into state.
- Storage: word[0..7], each WIDTH bits. Bit ordering of in, out and each word is identical to the 16-bit gate family.
- Reset: at a rising edge with rst=1, all 8 words become 0. out therefore reads 0 at every address after reset.
- Power-up contents before the first reset are undefined. The bench must not check them.
- Write: at a rising edge with rst=0 and load=1, word[address] <= in. The other 7 words hold.
- Hold: at a rising edge with rst=0 and load=0, no word changes.
- Read: out = word[address], combinational from address. There is no read latency.
- Write latency: a written value appears on out starting with the cycle after the edge (1-cycle write-to-read latency).
- Same-cycle read of the word being written returns the old value until the edge (no bypass in the base build).
- rst=1 together with load=1: reset wins and the write is discarded.
- Reset asserted mid-sequence clears all words at that edge. Writes resume at the first edge with rst=0.
- Address changes between edges: out follows combinationally. There are no glitch requirements beyond settling before the next edge.
- load is sampled only at edges. Pulses between edges have no effect.
- Every address value 0..7 is valid. There is no out-of-range case.

Optional Feature:
- Macro: RAM8_16_WRITE_BYPASS_EN.
- Defined: when load=1 and rst=0, out = in combinationally for the current address (write-through forward). After the edge, out = word[address] as normal. When rst=1, out is not forwarded.
- Undefined: out always equals stored word[address]; a same-cycle write is not visible until after the edge.

Decomposition:
- Shared package/header hack_defs: HACK_WORD_W = 16, RAM8_ADDR_W = 3, RAM8_DEPTH = 8, and the reset word value HACK_WORD_ZERO = 16'h0000.
- Sub-module register16: WIDTH-bit register with clk, rst (sync, active-high, clears to 0), in, load, out.
- ram8_16 instantiates 8 register16 instances, a 3-to-8 load decoder and an 8:1 output mux.

Test Plan:
- Reset: rst=1 for 1 edge, then read address 0..7 -> out = 16'h0000 at every address.
- Write/readback: for a = 0..7, write in = 16'h1111*(a+1) with load=1. Then load=0 and sweep address 0..7 -> out = 16'h1111, 16'h2222, ... 16'h8888. No other word is disturbed after each write.
- Hold: address=3, in=16'hffff, load=0 for 3 edges -> out stays 16'h4444.
- Write latency: address=5, in=16'ha5a5, load=1. Before the edge, out = 16'h6666; after the edge, out = 16'ha5a5. With RAM8_16_WRITE_BYPASS_EN, out = 16'ha5a5 before the edge as well.
- Reset priority: all words nonzero, then rst=1, load=1, address=2, in=16'hbeef for 1 edge -> all 8 words = 16'h0000, and address 2 reads 16'h0000, not 16'hbeef.
- Reset mid-operation: write 16'h00ff to address 7, assert rst for one edge, then write 16'hf00f to address 7 -> out = 16'h0000 after the reset edge and 16'hf00f after the next write edge.
